// File: rtl/fp_to_int_pipe.sv
// Three-stage binary32 -> 32-bit integer converter (FCVT.W.S / FCVT.WU.S).
// S1 unpacks, S2 aligns to an integer magnitude with guard/sticky, S3 rounds and saturates.
module fp_to_int_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_f,
  input  logic [2:0]  in_rm,
  input  logic        in_is_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_int,
  output logic        out_nv,
  output logic        out_nx
);
  // vld_pipe[0..2] tracks S1..S3; the last bit is the output stage
  localparam int STAGES = 2;

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  typedef struct packed {
    logic        s;
    logic [23:0] m;
    logic [8:0]  exp;
    logic        nan;
    logic        inf;
    logic [2:0]  rm;
    logic        uns;
  } s1_t;

  typedef struct packed {
    logic        s;
    logic [31:0] mag;
    logic        guard;
    logic        sticky;
    logic        ovf;
    logic        nan;
    logic        inf;
    logic [2:0]  rm;
    logic        uns;
  } s2_t;

  logic [STAGES:0] vld_pipe;
  logic            adv;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [8:0]      e_m23, e_r;
  logic [31:0]     lsh;
  logic [47:0]     wide;
  logic            inc, inexact;
  logic [32:0]     r;
  logic [31:0]     res_d;
  logic            nv_d, nx_d;

  assign adv       = ~vld_pipe[STAGES] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  always_comb begin
    s1_d     = '0;
    s1_d.s   = in_f[31];
    s1_d.m   = {|in_f[30:23], in_f[22:0]};
    s1_d.exp = {1'b0, in_f[30:23]} - 9'd127;
    s1_d.nan = (&in_f[30:23]) & (|in_f[22:0]);
    s1_d.inf = (&in_f[30:23]) & ~(|in_f[22:0]);
    s1_d.rm  = in_rm;
    s1_d.uns = in_is_unsigned;
  end

  // Both shifts are formed unconditionally; only the branch matching E is used.
  assign e_m23 = s1_q.exp - 9'd23;
  assign e_r   = 9'd23 - s1_q.exp;
  assign lsh   = {8'b0, s1_q.m} << e_m23;
  assign wide  = {s1_q.m, 24'b0} >> e_r;

  always_comb begin
    s2_d     = '0;
    s2_d.s   = s1_q.s;
    s2_d.nan = s1_q.nan;
    s2_d.inf = s1_q.inf;
    s2_d.rm  = s1_q.rm;
    s2_d.uns = s1_q.uns;
    if (s1_q.nan | s1_q.inf) begin
      s2_d.mag = '0;
    end else if ($signed(s1_q.exp) >= 9'sd32) begin
      s2_d.ovf = 1'b1;
    end else if ($signed(s1_q.exp) >= 9'sd23) begin
      s2_d.mag = lsh;
    end else if ($signed(s1_q.exp) >= -9'sd1) begin
      s2_d.mag    = {8'b0, wide[47:24]};
      s2_d.guard  = wide[23];
      s2_d.sticky = |wide[22:0];
    end else begin
      s2_d.sticky = |s1_q.m;
    end
  end

  always_comb begin
    case (s2_q.rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s2_q.s & (s2_q.guard | s2_q.sticky);
      RM_RUP:  inc = ~s2_q.s & (s2_q.guard | s2_q.sticky);
      RM_RMM:  inc = s2_q.guard;
      default: inc = s2_q.guard & (s2_q.sticky | s2_q.mag[0]);
    endcase
  end

  assign r       = {1'b0, s2_q.mag} + {32'b0, inc};
  assign inexact = s2_q.guard | s2_q.sticky;

  always_comb begin
    res_d = '0;
    nv_d  = 1'b0;
    nx_d  = 1'b0;
    if (!s2_q.uns) begin
      if (s2_q.nan | (s2_q.inf & ~s2_q.s)) begin
        res_d = 32'h7FFF_FFFF;
        nv_d  = 1'b1;
      end else if (s2_q.inf) begin
        res_d = 32'h8000_0000;
        nv_d  = 1'b1;
      end else if (~s2_q.s & (s2_q.ovf | (r > 33'h0_7FFF_FFFF))) begin
        res_d = 32'h7FFF_FFFF;
        nv_d  = 1'b1;
      end else if (s2_q.s & (s2_q.ovf | (r > 33'h0_8000_0000))) begin
        res_d = 32'h8000_0000;
        nv_d  = 1'b1;
      end else begin
        res_d = s2_q.s ? -r[31:0] : r[31:0];
        nx_d  = inexact;
      end
    end else begin
      if (s2_q.nan | (s2_q.inf & ~s2_q.s)) begin
        res_d = 32'hFFFF_FFFF;
        nv_d  = 1'b1;
      end else if (s2_q.inf) begin
        nv_d  = 1'b1;
      end else if (~s2_q.s & (s2_q.ovf | r[32])) begin
        res_d = 32'hFFFF_FFFF;
        nv_d  = 1'b1;
      end else if (s2_q.s & (s2_q.ovf | (r != 33'd0))) begin
        nv_d  = 1'b1;
      end else if (s2_q.s) begin
        // small negatives that round to zero are representable, just inexact
        nx_d  = inexact;
      end else begin
        res_d = r[31:0];
        nx_d  = inexact;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      out_int  <= '0;
      out_nv   <= 1'b0;
      out_nx   <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      out_int  <= res_d;
      out_nv   <= nv_d;
      out_nx   <= nx_d;
    end
  end
endmodule
